prv_trap_ctrl: RTL

//  Parametrised machine-mode trap controller on the privilege side of the CSR regfile.

---
 rtl/machine_mode_types_pkg.sv | 31 +++
 rtl/prv_int_prio_enc.sv | 41 ++++
 rtl/prv_trap_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/machine_mode_types_pkg.sv
// ----------------------------------------------------------------------------
// machine_mode_types_pkg
// Shared machine-mode types and constants for the privilege-side CSR logic.
//   trap_state_t   : trap controller FSM states
//   CAUSE_*        : interrupt cause codes; also the matching mip/mie bit index
//   MSTATUS_*      : bit positions inside mstatus
//   CAUSE_W        : width of a latched cause (exception codes and ext lines)
// ----------------------------------------------------------------------------
package machine_mode_types_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      COMMIT = 2'd2,
      RETURN = 2'd3
   } trap_state_t;

   localparam int CAUSE_MSI      = 3;
   localparam int CAUSE_MTI      = 7;
   localparam int CAUSE_MEI      = 11;
   localparam int CAUSE_EXT_BASE = 16;

   // Five bits cover exception codes (4 bits) and ext causes up to 16+15.
   localparam int CAUSE_W = 5;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/prv_int_prio_enc.sv
// ----------------------------------------------------------------------------
// prv_int_prio_enc
// Combinational priority encoder for enabled, pending machine interrupts.
// Order: external lines (lowest index first) > software > timer.
//   ext_pend_i    in  NUM_EXT_INT  pending+enabled external lines
//   soft_pend_i   in  1            pending+enabled software interrupt
//   timer_pend_i  in  1            pending+enabled timer interrupt
//   valid_o       out 1            any interrupt selected
//   cause_o       out CAUSE_W      cause code of the selected interrupt
// ----------------------------------------------------------------------------
module prv_int_prio_enc
   import machine_mode_types_pkg::*;
#(
   parameter int NUM_EXT_INT = 4
) (
   input  logic [NUM_EXT_INT-1:0] ext_pend_i,
   input  logic                   soft_pend_i,
   input  logic                   timer_pend_i,
   output logic                   valid_o,
   output logic [CAUSE_W-1:0]     cause_o
);

   // Scanning external lines from the top down lets the lowest pending
   // index overwrite the others, giving it the highest priority.
   always_comb begin
      valid_o = (|ext_pend_i) | soft_pend_i | timer_pend_i;
      cause_o = '0;
      if (|ext_pend_i) begin
         for (int i = NUM_EXT_INT - 1; i >= 0; i--) begin
            if (ext_pend_i[i]) begin
               cause_o = CAUSE_W'(CAUSE_EXT_BASE + i);
            end
         end
      end else if (soft_pend_i) begin
         cause_o = CAUSE_W'(CAUSE_MSI);
      end else if (timer_pend_i) begin
         cause_o = CAUSE_W'(CAUSE_MTI);
      end
   end

endmodule

// File: rtl/prv_trap_ctrl.sv
// ----------------------------------------------------------------------------
// prv_trap_ctrl
// Machine-mode trap controller. Takes synchronous exceptions and external,
// software and timer interrupts, drains the pipeline, writes the trap CSRs
// through one-cycle update strobes, redirects fetch to mtvec and handles MRET.
//   clk_i, rst_i           clock, synchronous active-high reset
//   ext_int_i/timer_int_i/soft_int_i   level interrupt lines (registered once)
//   exc_valid_i/exc_code_i/exc_epc_i/exc_badaddr_i   exception from pipeline
//   int_epc_i              resume PC for interrupts
//   mret_i                 MRET at commit
//   pipe_idle_i            pipeline drained (acknowledges flush_req_o)
//   mstatus_i/mie_i/mtvec_i/mepc_i     current CSR values
//   flush_req_o            stall/flush the pipeline
//   redirect_valid_o/redirect_pc_o     one-cycle fetch redirect
//   *_rup_o / *_next_o     CSR update strobes and values
//   busy_o                 FSM not idle
// ----------------------------------------------------------------------------
module prv_trap_ctrl
   import machine_mode_types_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int NUM_EXT_INT = 4,
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_EXT_INT-1:0] ext_int_i,
   input  logic                   timer_int_i,
   input  logic                   soft_int_i,
   input  logic                   exc_valid_i,
   input  logic [3:0]             exc_code_i,
   input  logic [XLEN-1:0]        exc_epc_i,
   input  logic [XLEN-1:0]        exc_badaddr_i,
   input  logic [XLEN-1:0]        int_epc_i,
   input  logic                   mret_i,
   input  logic                   pipe_idle_i,
   input  logic [XLEN-1:0]        mstatus_i,
   input  logic [XLEN-1:0]        mie_i,
   input  logic [XLEN-1:0]        mtvec_i,
   input  logic [XLEN-1:0]        mepc_i,
   output logic                   flush_req_o,
   output logic                   redirect_valid_o,
   output logic [XLEN-1:0]        redirect_pc_o,
   output logic                   mip_rup_o,
   output logic                   mcause_rup_o,
   output logic                   mepc_rup_o,
   output logic                   mbadaddr_rup_o,
   output logic                   mstatus_rup_o,
   output logic [XLEN-1:0]        mip_next_o,
   output logic [XLEN-1:0]        mcause_next_o,
   output logic [XLEN-1:0]        mepc_next_o,
   output logic [XLEN-1:0]        mbadaddr_next_o,
   output logic [XLEN-1:0]        mstatus_next_o,
   output logic                   busy_o
);

   trap_state_t            state_q, state_d;
   logic [NUM_EXT_INT-1:0] ext_q;
   logic                   timer_q, soft_q;
   logic [CAUSE_W-1:0]     cause_q, cause_d;
   logic                   int_q, int_d;
   logic [XLEN-1:0]        epc_q, epc_d;
   logic [XLEN-1:0]        bad_q, bad_d;

   logic [XLEN-1:0]        mipVal;
   logic [XLEN-1:0]        pendVec;
   logic                   prioValid;
   logic [CAUSE_W-1:0]     prioCause;
   logic [XLEN-1:0]        vecOffset;
   logic [XLEN-1:0]        tvecTarget;
   logic [XLEN-1:0]        trapMstatus;
   logic [XLEN-1:0]        retMstatus;
   logic                   unusedBits;

   // Build the mip image from the registered lines; bit 11 summarises all
   // external lines while each line also has its own bit at 16+i.
   always_comb begin
      mipVal                                = '0;
      mipVal[CAUSE_MSI]                     = soft_q;
      mipVal[CAUSE_MTI]                     = timer_q;
      mipVal[CAUSE_MEI]                     = |ext_q;
      mipVal[CAUSE_EXT_BASE +: NUM_EXT_INT] = ext_q;
   end

   assign pendVec    = mipVal & mie_i & {XLEN{mstatus_i[MSTATUS_MIE]}};
   assign unusedBits = ^{pendVec, epc_q[1:0]};

   prv_int_prio_enc #(
      .NUM_EXT_INT (NUM_EXT_INT)
   ) u_prio (
      .ext_pend_i   (pendVec[CAUSE_EXT_BASE +: NUM_EXT_INT]),
      .soft_pend_i  (pendVec[CAUSE_MSI]),
      .timer_pend_i (pendVec[CAUSE_MTI]),
      .valid_o      (prioValid),
      .cause_o      (prioCause)
   );

   // Vectored mode only offsets interrupts; exceptions always land on base.
   assign vecOffset  = (VECTORED_EN && (mtvec_i[1:0] == 2'b01) && int_q)
                       ? {{(XLEN-CAUSE_W-2){1'b0}}, cause_q, 2'b00} : '0;
   assign tvecTarget = {mtvec_i[XLEN-1:2], 2'b00} + vecOffset;

   // mstatus images for trap entry (stack MIE into MPIE) and MRET (unstack).
   always_comb begin
      trapMstatus                                = mstatus_i;
      trapMstatus[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
      trapMstatus[MSTATUS_MIE]                   = 1'b0;
      trapMstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      retMstatus                                 = mstatus_i;
      retMstatus[MSTATUS_MIE]                    = mstatus_i[MSTATUS_MPIE];
      retMstatus[MSTATUS_MPIE]                   = 1'b1;
      retMstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
   end

   // Trap selection happens only in IDLE; once latched, the trap record is
   // frozen until COMMIT so late exceptions or dropped interrupts are ignored.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      int_d   = int_q;
      epc_d   = epc_q;
      bad_d   = bad_q;
      case (state_q)
         IDLE: begin
            if (exc_valid_i) begin
               state_d = FLUSH;
               cause_d = {1'b0, exc_code_i};
               int_d   = 1'b0;
               epc_d   = exc_epc_i;
               bad_d   = exc_badaddr_i;
            end else if (prioValid) begin
               state_d = FLUSH;
               cause_d = prioCause;
               int_d   = 1'b1;
               epc_d   = int_epc_i;
               bad_d   = '0;
            end else if (mret_i) begin
               state_d = RETURN;
            end
         end
         FLUSH: begin
            if (pipe_idle_i) begin
               state_d = COMMIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, trap record and the interrupt sync stage; reset abandons any
   // trap in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ext_q   <= '0;
         timer_q <= 1'b0;
         soft_q  <= 1'b0;
         cause_q <= '0;
         int_q   <= 1'b0;
         epc_q   <= '0;
         bad_q   <= '0;
      end else begin
         state_q <= state_d;
         ext_q   <= ext_int_i;
         timer_q <= timer_int_i;
         soft_q  <= soft_int_i;
         cause_q <= cause_d;
         int_q   <= int_d;
         epc_q   <= epc_d;
         bad_q   <= bad_d;
      end
   end

   // Outputs decode directly from the state; everything is held at zero
   // while reset is asserted so an aborted trap never leaks a strobe.
   always_comb begin
      flush_req_o      = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      mip_rup_o        = 1'b0;
      mcause_rup_o     = 1'b0;
      mepc_rup_o       = 1'b0;
      mbadaddr_rup_o   = 1'b0;
      mstatus_rup_o    = 1'b0;
      mip_next_o       = '0;
      mcause_next_o    = '0;
      mepc_next_o      = '0;
      mbadaddr_next_o  = '0;
      mstatus_next_o   = '0;
      busy_o           = 1'b0;
      if (!rst_i) begin
         mip_rup_o  = 1'b1;
         mip_next_o = mipVal;
         busy_o     = (state_q != IDLE);
         case (state_q)
            FLUSH: flush_req_o = 1'b1;
            COMMIT: begin
               flush_req_o      = 1'b1;
               mcause_rup_o     = 1'b1;
               mepc_rup_o       = 1'b1;
               mbadaddr_rup_o   = 1'b1;
               mstatus_rup_o    = 1'b1;
               mcause_next_o    = {int_q, {(XLEN-CAUSE_W-1){1'b0}}, cause_q};
               mepc_next_o      = {epc_q[XLEN-1:2], 2'b00};
               mbadaddr_next_o  = bad_q;
               mstatus_next_o   = trapMstatus;
               redirect_valid_o = 1'b1;
               redirect_pc_o    = tvecTarget;
            end
            RETURN: begin
               mstatus_rup_o    = 1'b1;
               mstatus_next_o   = retMstatus;
               redirect_valid_o = 1'b1;
               redirect_pc_o    = mepc_i;
            end
            default: ;
         endcase
      end
   end

endmodule
